// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the ALU and memory writeback requests, the register file write
// port, the PC write port and the decode hazard-check signals.
//   master : the execute/memory/decode side, which drives requests and
//            read addresses and observes the write port and hazard flags
//   slave  : the arbiter, which consumes requests and drives the write port
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;

  logic              mem_valid_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;

  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;

  logic              pc_wr_o;
  logic [DATA_W-1:0] pc_data_o;

  logic [ADDR_W-1:0] rd_a_addr_i;
  logic [ADDR_W-1:0] rd_b_addr_i;
  logic              pending_a_o;
  logic              pending_b_o;

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output mem_valid_i, mem_addr_i, mem_data_i,
    output rd_a_addr_i, rd_b_addr_i,
    input  alu_ready_o,
    input  wr_en_o, wr_addr_o, wr_data_o,
    input  pc_wr_o, pc_data_o,
    input  pending_a_o, pending_b_o
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  mem_valid_i, mem_addr_i, mem_data_i,
    input  rd_a_addr_i, rd_b_addr_i,
    output alu_ready_o,
    output wr_en_o, wr_addr_o, wr_data_o,
    output pc_wr_o, pc_data_o,
    output pending_a_o, pending_b_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter.
// Shares the single register file write port between memory loads (always
// win, never back-pressured) and ALU results (buffered in a small FIFO with
// valid/ready). Writes to register 15 are redirected to the PC port. A
// combinational scoreboard flags reads whose register still has a write
// queued or sitting in the output stage.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : regfile_wb_arbiter_if.slave (ALU/mem requests, write port,
//           PC port, hazard scoreboard)
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FIFO_DEPTH);

  // ALU writeback buffer
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  // Output stage
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              pc_wr_q;
  logic [DATA_W-1:0] pc_data_q;

  // Arbitration results
  logic              alu_ready_c;
  logic              alu_acc_c;
  logic              push_c;
  logic              pop_c;
  logic              win_valid_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_data_c;

  // Ready is evaluated before any pop, so a full FIFO never accepts.
  assign alu_ready_c = !rst_i && (count < CNT_MAX);
  assign alu_acc_c   = bus.alu_valid_i && alu_ready_c;

  // Winner selection: mem > FIFO head > ALU bypass
  always_comb begin
    push_c      = 1'b0;
    pop_c       = 1'b0;
    win_valid_c = 1'b0;
    win_addr_c  = '0;
    win_data_c  = '0;
    if (bus.mem_valid_i) begin
      win_valid_c = 1'b1;
      win_addr_c  = bus.mem_addr_i;
      win_data_c  = bus.mem_data_i;
      push_c      = alu_acc_c;
    end else if (count != '0) begin
      win_valid_c = 1'b1;
      win_addr_c  = fifo_addr[rd_ptr];
      win_data_c  = fifo_data[rd_ptr];
      pop_c       = 1'b1;
      push_c      = alu_acc_c;
    end else if (alu_acc_c) begin
      // Empty FIFO: ALU result goes straight to the output stage.
      win_valid_c = 1'b1;
      win_addr_c  = bus.alu_addr_i;
      win_data_c  = bus.alu_data_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      fifo_addr[wr_ptr] <= bus.alu_addr_i;
      fifo_data[wr_ptr] <= bus.alu_data_i;
    end
  end

  // Output stage: each winner is presented for exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pc_wr_q   <= 1'b0;
      pc_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      pc_wr_q <= 1'b0;
      if (win_valid_c) begin
        if (win_addr_c == PC_ADDR) begin
          pc_wr_q   <= 1'b1;
          pc_data_q <= win_data_c;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= win_addr_c;
          wr_data_q <= win_data_c;
        end
      end
    end
  end

  // Hazard scoreboard over live FIFO entries and the output stage.
  logic             pend_a_c, pend_b_c;
  logic [PTR_W-1:0] offs_c;
  always_comb begin
    pend_a_c = (wr_en_q && (wr_addr_q == bus.rd_a_addr_i)) ||
               (pc_wr_q && (bus.rd_a_addr_i == PC_ADDR));
    pend_b_c = (wr_en_q && (wr_addr_q == bus.rd_b_addr_i)) ||
               (pc_wr_q && (bus.rd_b_addr_i == PC_ADDR));
    offs_c   = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      // Entry i is live when its distance from the head is below count.
      offs_c = PTR_W'(i) - rd_ptr;
      if (CNT_W'(offs_c) < count) begin
        if (fifo_addr[i] == bus.rd_a_addr_i) pend_a_c = 1'b1;
        if (fifo_addr[i] == bus.rd_b_addr_i) pend_b_c = 1'b1;
      end
    end
  end

  assign bus.alu_ready_o = alu_ready_c;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.pc_wr_o     = pc_wr_q;
  assign bus.pc_data_o   = pc_data_q;
  assign bus.pending_a_o = pend_a_c;
  assign bus.pending_b_o = pend_b_c;

endmodule
